bsg_clk_gen_pearl_freq_meter: RTL and testbench

BSG_CLK_GEN_PEARL_FREQ_METER -- requirements
Module: bsg_clk_gen_pearl_freq_meter

---
 rtl/bsg_clk_gen_pearl_freq_meter.sv | 87 ++++++++
 tb/tb_bsg_clk_gen_pearl_freq_meter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_clk_gen_pearl_freq_meter.sv
// rtl/bsg_clk_gen_pearl_freq_meter.sv - counts monitor clock rising edges over an N-cycle reference window
module bsg_clk_gen_pearl_freq_meter #(
    parameter int window_width_p = 16,
    parameter int count_width_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      monitor_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic                      start_i,
    input  logic                      continuous_i,
    output logic                      busy_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [count_width_p-1:0]  count_o,
    output logic                      overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                    state_q;
    logic                      sync1_q;
    logic                      sync2_q;
    logic                      prev_q;
    logic [window_width_p-1:0] win_q;
    logic [count_width_p-1:0]  cnt_q;
    logic                      ovf_q;

    logic rise_d;
    logic trigger_d;
    logic load_d;
    logic sat_d;

    assign rise_d    = sync2_q & ~prev_q;
    assign trigger_d = start_i | continuous_i;
    // A new window may open from IDLE, or from DONE in the same cycle the result is taken.
    assign load_d    = trigger_d & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & yumi_i));
    assign sat_d     = &cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= monitor_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (load_d) begin
                win_q   <= window_i;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                state_q <= (window_i == '0) ? ST_DONE : ST_COUNT;
            end else begin
                case (state_q)
                    ST_COUNT: begin
                        win_q <= win_q - window_width_p'(1);
                        if (rise_d) begin
                            if (sat_d) ovf_q <= 1'b1;
                            else       cnt_q <= cnt_q + count_width_p'(1);
                        end
                        if (win_q == window_width_p'(1)) state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        if (yumi_i) state_q <= ST_IDLE;
                    end
                    ST_IDLE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o     = (state_q == ST_COUNT);
    assign v_o        = (state_q == ST_DONE);
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_freq_meter.sv
// tb/tb_bsg_clk_gen_pearl_freq_meter.sv - directed self-checking bench for the frequency meter
module tb_bsg_clk_gen_pearl_freq_meter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        monitor = 1'b0;
    logic [15:0] window = '0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        yumi = 1'b0;
    logic        busy, v, ovf;
    logic [15:0] count;
    logic        busy4, v4, ovf4;
    logic [3:0]  count4;

    int passed = 0;
    int total  = 0;
    int mon_period = 0;
    int mon_phase  = 0;

    always #5 clk = ~clk;

    bsg_clk_gen_pearl_freq_meter #(.window_width_p(16), .count_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .monitor_i(monitor), .window_i(window),
        .start_i(start), .continuous_i(cont), .busy_o(busy), .v_o(v), .yumi_i(yumi),
        .count_o(count), .overflow_o(ovf)
    );

    bsg_clk_gen_pearl_freq_meter #(.window_width_p(16), .count_width_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .monitor_i(monitor), .window_i(window),
        .start_i(start), .continuous_i(cont), .busy_o(busy4), .v_o(v4), .yumi_i(yumi),
        .count_o(count4), .overflow_o(ovf4)
    );

    // Monitor square wave, period mon_period clk cycles, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_period < 2) begin
                monitor = 1'b0;
            end else begin
                mon_phase = (mon_phase + 1) % mon_period;
                monitor = (mon_phase < mon_period / 2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [15:0] n);
        start  = 1'b1;
        window = n;
        step();
        start  = 1'b0;
        window = 16'hFFFF;
    endtask

    task automatic wait_v(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (!v && cyc < 500) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
        if (!v) cyc = -1;
    endtask

    task automatic consume();
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        total++;
        if ({busy, v, ovf} !== 3'b000 || count !== 16'd0) $display("FAIL reset_state: busy=%0b v=%0b ovf=%0b count=%0d want 0 0 0 0", busy, v, ovf, count);
        else passed++;
        reset_n = 1'b1;
        repeat (3) step();
        total++;
        if ({busy, v, ovf} !== 3'b000 || count !== 16'd0) $display("FAIL idle_after_reset: busy=%0b v=%0b ovf=%0b count=%0d want 0 0 0 0", busy, v, ovf, count);
        else passed++;
    endtask

    task automatic test_single();
        int cyc, bc;
        mon_period = 4;
        repeat (8) step();
        kick(16'd100);
        wait_v(cyc, bc);
        total++;
        if (cyc !== 100) $display("FAIL single_latency: got %0d cycles want 100", cyc);
        else passed++;
        total++;
        if (bc !== 100) $display("FAIL single_busy: got %0d busy cycles want 100", bc);
        else passed++;
        total++;
        if (count !== 16'd25 && count !== 16'd24) $display("FAIL single_count: got %0d want 25 (or 24)", count);
        else passed++;
        total++;
        if (ovf !== 1'b0) $display("FAIL single_ovf: got %0b want 0", ovf);
        else passed++;
        consume();
        total++;
        if (v !== 1'b0 || busy !== 1'b0) $display("FAIL single_consume: v=%0b busy=%0b want 0 0", v, busy);
        else passed++;
    endtask

    task automatic test_exact_period5();
        int cyc, bc;
        mon_period = 5;
        repeat (10) step();
        kick(16'd20);
        wait_v(cyc, bc);
        total++;
        if (cyc !== 20 || count !== 16'd4) $display("FAIL period5_count: cyc=%0d count=%0d want 20 4", cyc, count);
        else passed++;
        consume();
    endtask

    task automatic test_zero_window();
        int cyc, bc;
        kick(16'd0);
        total++;
        if (v !== 1'b1) $display("FAIL zero_v: got %0b want 1", v);
        else passed++;
        total++;
        if (busy !== 1'b0 || count !== 16'd0 || ovf !== 1'b0) $display("FAIL zero_result: busy=%0b count=%0d ovf=%0b want 0 0 0", busy, count, ovf);
        else passed++;
        wait_v(cyc, bc);
        total++;
        if (cyc !== 0 || bc !== 0) $display("FAIL zero_latency: cyc=%0d busy=%0d want 0 0", cyc, bc);
        else passed++;
        consume();
    endtask

    task automatic test_overflow();
        int cyc, bc;
        mon_period = 2;
        repeat (6) step();
        kick(16'd64);
        wait_v(cyc, bc);
        total++;
        if (v4 !== 1'b1 || count4 !== 4'd15 || ovf4 !== 1'b1) $display("FAIL overflow_narrow: v=%0b count=%0d ovf=%0b want 1 15 1", v4, count4, ovf4);
        else passed++;
        total++;
        if (count !== 16'd32 || ovf !== 1'b0) $display("FAIL overflow_wide: count=%0d ovf=%0b want 32 0", count, ovf);
        else passed++;
        consume();
    endtask

    task automatic test_back_pressure();
        int cyc, bc;
        logic hold_ok;
        mon_period = 4;
        repeat (8) step();
        kick(16'd8);
        wait_v(cyc, bc);
        total++;
        if (cyc !== 8 || count !== 16'd2 || ovf !== 1'b0) $display("FAIL bp_result: cyc=%0d count=%0d ovf=%0b want 8 2 0", cyc, count, ovf);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            start  = i[0];
            window = 16'(i * 3);
            step();
            hold_ok = (v === 1'b1) && (busy === 1'b0) && (count === 16'd2) && (ovf === 1'b0);
            total++;
            if (!hold_ok) $display("FAIL bp_hold_%0d: v=%0b busy=%0b count=%0d ovf=%0b want 1 0 2 0", i, v, busy, count, ovf);
            else passed++;
        end
        start = 1'b0;
        consume();
        total++;
        if (v !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: v=%0b busy=%0b want 0 0", v, busy);
        else passed++;
    endtask

    task automatic test_continuous();
        int cyc, bc;
        cont   = 1'b1;
        yumi   = 1'b1;
        window = 16'd10;
        wait_v(cyc, bc);
        total++;
        if (cyc !== 11 || bc !== 10) $display("FAIL cont_first: cyc=%0d busy=%0d want 11 10", cyc, bc);
        else passed++;
        for (int r = 0; r < 3; r++) begin
            step();
            total++;
            if (v !== 1'b0 || busy !== 1'b1) $display("FAIL cont_restart_%0d: v=%0b busy=%0b want 0 1", r, v, busy);
            else passed++;
            wait_v(cyc, bc);
            total++;
            if (cyc !== 10 || bc !== 10) $display("FAIL cont_period_%0d: cyc=%0d busy=%0d want 10 10", r, cyc, bc);
            else passed++;
        end
        cont = 1'b0;
        step();
        yumi = 1'b0;
        total++;
        if (v !== 1'b0 || busy !== 1'b0) $display("FAIL cont_stop: v=%0b busy=%0b want 0 0", v, busy);
        else passed++;
    endtask

    task automatic test_reset_mid_count();
        int cyc, bc;
        logic quiet;
        mon_period = 4;
        kick(16'd100);
        repeat (4) step();
        total++;
        if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %0b want 1", busy);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, v, ovf} !== 3'b000 || count !== 16'd0) $display("FAIL rst_async: busy=%0b v=%0b ovf=%0b count=%0d want 0 0 0 0", busy, v, ovf, count);
        else passed++;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (v !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) $display("FAIL rst_no_result: outputs active after release without trigger");
        else passed++;
        kick(16'd4);
        wait_v(cyc, bc);
        total++;
        if (cyc !== 4 || count !== 16'd1) $display("FAIL rst_new_meas: cyc=%0d count=%0d want 4 1", cyc, count);
        else passed++;
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_exact_period5();
        test_zero_window();
        test_overflow();
        test_back_pressure();
        test_continuous();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
